// File: rtl/decode_queue_pkg.sv
// rtl/decode_queue_pkg.sv - shared types and RV32I opcode constants for the decode queue
package decode_queue_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP       = 7'b0110011;
    localparam logic [6:0] OP_IMM   = 7'b0010011;
    localparam logic [6:0] LOAD     = 7'b0000011;
    localparam logic [6:0] STORE    = 7'b0100011;
    localparam logic [6:0] BRANCH   = 7'b1100011;
    localparam logic [6:0] JAL      = 7'b1101111;
    localparam logic [6:0] JALR     = 7'b1100111;
    localparam logic [6:0] LUI      = 7'b0110111;
    localparam logic [6:0] AUIPC    = 7'b0010111;
    localparam logic [6:0] SYSTEM   = 7'b1110011;
    localparam logic [6:0] MISC_MEM = 7'b0001111;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } InsnFmt;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
    } Signals;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     insn;
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
        logic [31:0]     imm;
        InsnFmt          fmt;
        logic            illegal;
    } Decoded;

endpackage

// File: rtl/decode_queue_rv32i_decoder.sv
// rtl/decode_queue_rv32i_decoder.sv - combinational RV32I field extraction and immediate generation
module rv32i_decoder
    import decode_queue_pkg::*;
(
    input  logic [XLEN-1:0] pc_i,
    input  logic [31:0]     insn_i,
    output Decoded          dec_o
);

    always_comb begin
        dec_o         = '0;
        dec_o.pc      = pc_i;
        dec_o.insn    = insn_i;
        dec_o.opcode  = insn_i[6:0];
        dec_o.rd      = insn_i[11:7];
        dec_o.rs1     = insn_i[19:15];
        dec_o.rs2     = insn_i[24:20];
        dec_o.funct3  = insn_i[14:12];
        dec_o.funct7  = insn_i[31:25];
        dec_o.imm     = '0;
        dec_o.fmt     = FMT_R;
        dec_o.illegal = 1'b0;

        case (insn_i[6:0])
            OP: begin
                dec_o.fmt = FMT_R;
            end
            OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: begin
                dec_o.fmt = FMT_I;
                dec_o.imm = {{20{insn_i[31]}}, insn_i[31:20]};
            end
            STORE: begin
                dec_o.fmt = FMT_S;
                dec_o.imm = {{20{insn_i[31]}}, insn_i[31:25], insn_i[11:7]};
            end
            BRANCH: begin
                dec_o.fmt = FMT_B;
                dec_o.imm = {{19{insn_i[31]}}, insn_i[31], insn_i[7],
                             insn_i[30:25], insn_i[11:8], 1'b0};
            end
            LUI, AUIPC: begin
                dec_o.fmt = FMT_U;
                dec_o.imm = {insn_i[31:12], 12'b0};
            end
            JAL: begin
                dec_o.fmt = FMT_J;
                dec_o.imm = {{11{insn_i[31]}}, insn_i[31], insn_i[19:12],
                             insn_i[20], insn_i[30:21], 1'b0};
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase

        // Compressed encodings are not supported; they trap downstream.
        if (insn_i[1:0] != 2'b11) begin
            dec_o.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - fetch consumer: filters beats by expected pc, decodes, buffers for execute
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = decode_queue_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  Signals          i_signals,
    output logic            o_stall,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            o_valid,
    input  logic            i_ready,
    output Decoded          o_dec
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] STALL_LVL = CW'(DEPTH - 1);

    Decoded          mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] expected_pc_q, expected_pc_d;
    logic            stall_q, stall_d;

    Decoded dec_w;
    logic   enq_w;
    logic   deq_w;

    rv32i_decoder u_decoder (
        .pc_i   (i_signals.pc),
        .insn_i (i_signals.insn),
        .dec_o  (dec_w)
    );

    assign o_valid = (count_q != '0);
    assign o_dec   = o_valid ? mem_q[rd_ptr_q] : '0;
    assign o_stall = stall_q;

    // Count is sampled before dequeue, so a full queue refuses a beat even when the head leaves.
    assign enq_w = i_signals.valid && (i_signals.pc == expected_pc_q)
                   && (count_q < DEPTH_C) && !flush;
    assign deq_w = o_valid && i_ready && !flush;

    always_comb begin
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        expected_pc_d = expected_pc_q;
        stall_d       = stall_q;

        if (flush) begin
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            expected_pc_d = flush_pc;
            stall_d       = 1'b0;
        end else begin
            if (enq_w) begin
                wr_ptr_d      = wr_ptr_q + PW'(1);
                expected_pc_d = expected_pc_q + XLEN'(4);
            end
            if (deq_w) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(enq_w) - CW'(deq_w);
            // Stall one slot early to absorb the beat fetch issues before it sees the stall.
            stall_d = (count_d >= STALL_LVL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            expected_pc_q <= '0;
            stall_q       <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            expected_pc_q <= expected_pc_d;
            stall_q       <= stall_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && enq_w) begin
            mem_q[wr_ptr_q] <= dec_w;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (count_q <= DEPTH_C);
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - directed self-checking bench for decode_queue
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] BEQ_M4  = 32'hFE000EE3;
    localparam logic [31:0] ALL_ONE = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        rst;
    Signals      sig;
    logic        o_stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        o_valid;
    logic        i_ready;
    Decoded      o_dec;

    int n_vec  = 0;
    int n_miss = 0;

    decode_queue #(.DEPTH(4), .XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_signals (sig),
        .o_stall   (o_stall),
        .flush     (flush),
        .flush_pc  (flush_pc),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_dec     (o_dec)
    );

    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic v, input logic [31:0] pc, input logic [31:0] insn);
        sig.valid = v;
        sig.pc    = pc;
        sig.insn  = insn;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        flush = 1'b0;
        i_ready = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        tick();
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] pc_f;
    logic        st;
    int          peak;
    int          got;

    initial begin
        rst = 1'b1;
        flush = 1'b0;
        flush_pc = 32'h0;
        i_ready = 1'b0;
        beat(1'b0, 32'h0, 32'h0);

        // Reset state
        do_reset();
        check_vec("rst_valid", 32'(o_valid), 32'd0);
        check_vec("rst_stall", 32'(o_stall), 32'd0);
        check_vec("rst_dec_zero", 32'(|o_dec), 32'd0);

        // T1: addi x1,x0,5 at pc 0
        beat(1'b1, 32'h0, ADDI_X1);
        tick();
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t1_valid", 32'(o_valid), 32'd1);
        check_vec("t1_rd", 32'(o_dec.rd), 32'd1);
        check_vec("t1_rs1", 32'(o_dec.rs1), 32'd0);
        check_vec("t1_imm", o_dec.imm, 32'd5);
        check_vec("t1_fmt", 32'(o_dec.fmt), 32'(FMT_I));
        check_vec("t1_illegal", 32'(o_dec.illegal), 32'd0);

        // T2: back-pressure with a fetch model that re-presents its pc while stalled
        do_reset();
        pc_f = 32'h0;
        peak = 0;
        for (int c = 0; c < 8; c++) begin
            beat(1'b1, pc_f, ADDI_X1);
            st = o_stall;
            tick();
            if (!st) pc_f = pc_f + 32'd4;
            if (int'(dut.count_q) > peak) peak = int'(dut.count_q);
            if (c == 1) check_vec("t2_stall_cnt2", 32'(o_stall), 32'd0);
            if (c == 2) check_vec("t2_stall_cnt3", 32'(o_stall), 32'd1);
        end
        check_vec("t2_peak", 32'(peak), 32'd4);
        i_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            beat(1'b1, pc_f, ADDI_X1);
            st = o_stall;
            if (o_valid) begin
                check_vec($sformatf("t2_out%0d", got), o_dec.pc, 32'(got * 4));
                got++;
            end
            tick();
            if (!st) pc_f = pc_f + 32'd4;
        end
        check_vec("t2_drained", 32'(got), 32'd5);

        // T3: gap beat dropped
        do_reset();
        beat(1'b1, 32'h0, ADDI_X1);
        tick();
        beat(1'b1, 32'h8, ADDI_X1);
        tick();
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t3_head0", o_dec.pc, 32'h0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_vec("t3_pc8_dropped", 32'(o_valid), 32'd0);
        beat(1'b1, 32'h4, ADDI_X1);
        tick();
        beat(1'b1, 32'h8, ADDI_X1);
        tick();
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t3_head4", o_dec.pc, 32'h4);
        i_ready = 1'b1;
        tick();
        check_vec("t3_head8_valid", 32'(o_valid), 32'd1);
        check_vec("t3_head8", o_dec.pc, 32'h8);
        tick();
        check_vec("t3_empty", 32'(o_valid), 32'd0);
        i_ready = 1'b0;

        // T4: flush with three entries, concurrent dequeue and valid beat
        do_reset();
        for (int k = 0; k < 3; k++) begin
            beat(1'b1, 32'(k * 4), ADDI_X1);
            tick();
        end
        check_vec("t4_pre_stall", 32'(o_stall), 32'd1);
        flush = 1'b1;
        flush_pc = 32'h40;
        i_ready = 1'b1;
        beat(1'b1, 32'hC, ADDI_X1);
        tick();
        flush = 1'b0;
        i_ready = 1'b0;
        check_vec("t4_valid", 32'(o_valid), 32'd0);
        check_vec("t4_count", 32'(dut.count_q), 32'd0);
        check_vec("t4_stall", 32'(o_stall), 32'd0);
        beat(1'b1, 32'h44, ADDI_X1);
        tick();
        check_vec("t4_44_dropped", 32'(o_valid), 32'd0);
        beat(1'b1, 32'h40, ADDI_X1);
        tick();
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t4_40_valid", 32'(o_valid), 32'd1);
        check_vec("t4_40_pc", o_dec.pc, 32'h40);

        // T5: branch immediate and illegal encoding
        do_reset();
        beat(1'b1, 32'h0, BEQ_M4);
        tick();
        beat(1'b1, 32'h4, ALL_ONE);
        tick();
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t5_fmt", 32'(o_dec.fmt), 32'(FMT_B));
        check_vec("t5_imm", o_dec.imm, 32'hFFFFFFFC);
        check_vec("t5_beq_legal", 32'(o_dec.illegal), 32'd0);
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
        check_vec("t5_ill_valid", 32'(o_valid), 32'd1);
        check_vec("t5_ill_pc", o_dec.pc, 32'h4);
        check_vec("t5_illegal", 32'(o_dec.illegal), 32'd1);

        // T6: reset overrides flush on a full queue
        do_reset();
        for (int k = 0; k < 4; k++) begin
            beat(1'b1, 32'(k * 4), ADDI_X1);
            tick();
        end
        check_vec("t6_full", 32'(dut.count_q), 32'd4);
        rst = 1'b1;
        flush = 1'b1;
        flush_pc = 32'h80;
        i_ready = 1'b1;
        beat(1'b1, 32'h10, ADDI_X1);
        tick();
        rst = 1'b0;
        flush = 1'b0;
        i_ready = 1'b0;
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t6_valid", 32'(o_valid), 32'd0);
        check_vec("t6_stall", 32'(o_stall), 32'd0);
        check_vec("t6_dec_zero", 32'(|o_dec), 32'd0);
        beat(1'b1, 32'h80, ADDI_X1);
        tick();
        check_vec("t6_80_dropped", 32'(o_valid), 32'd0);
        beat(1'b1, 32'h0, ADDI_X1);
        tick();
        beat(1'b0, 32'h0, 32'h0);
        check_vec("t6_pc0_valid", 32'(o_valid), 32'd1);
        check_vec("t6_pc0", o_dec.pc, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
